// File: rtl/controlador_rampa_temporizada_pkg.sv
// Shared types and defaults for the timed soft-start ramp sequencer.
// Holds the state enum, the default dwell constants and the level-step helpers.
package rampa_pkg;

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    VEL30  = 3'd1,
    VEL50  = 3'd2,
    VEL100 = 3'd3,
    FALLA  = 3'd4
  } estado_rampa_t;

  localparam int DWELL_RAPIDO_DEF = 4;
  localparam int DWELL_LENTO_DEF  = 16;
  localparam int CNT_W_DEF        = 8;

  // VEL100 is the top of the ramp, so stepping up from it holds the level.
  function automatic estado_rampa_t nivel_arriba(input estado_rampa_t e);
    case (e)
      VEL30:   return VEL50;
      VEL50:   return VEL100;
      default: return e;
    endcase
  endfunction

  function automatic estado_rampa_t nivel_abajo(input estado_rampa_t e);
    case (e)
      VEL100:  return VEL50;
      VEL50:   return VEL30;
      VEL30:   return REPOSO;
      default: return e;
    endcase
  endfunction

endpackage

// File: rtl/controlador_rampa_temporizada_if.sv
// Panel/power-stage signal bundle for the ramp sequencer.
// There is no handshake: every input is a level sampled on each rising clk edge,
// and every output is a registered level that changes only just after that edge.
interface controlador_rampa_temporizada_if;
  import rampa_pkg::*;

  logic Rapido;
  logic Lento;
  logic Parar;
  logic Falla;
  logic Reconocer;
  logic out_30;
  logic out_50;
  logic out_100;
  logic en_marcha;
  logic falla_activa;
  estado_rampa_t estado_dbg;

  modport master (
    output Rapido, Lento, Parar, Falla, Reconocer,
    input  out_30, out_50, out_100, en_marcha, falla_activa, estado_dbg
  );

  modport slave (
    input  Rapido, Lento, Parar, Falla, Reconocer,
    output out_30, out_50, out_100, en_marcha, falla_activa, estado_dbg
  );

endinterface

// File: rtl/controlador_rampa_temporizada_temporizador_paso.sv
// Loadable dwell down-counter; fin flags that the current step has elapsed.
module temporizador_paso #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cargar,
  input  logic [CNT_W-1:0] valor,
  output logic             fin
);

  logic [CNT_W-1:0] cnt;

  // Saturates at zero so a held level keeps reporting fin.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cargar) begin
      cnt <= valor;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign fin = (cnt == '0);

endmodule

// File: rtl/controlador_rampa_temporizada.sv
// Timed soft-start sequencer: ramps one-hot speed selects 0/30/50/100 % up and down,
// dwelling a mode-dependent number of cycles per step, with fault shutdown.
module controlador_rampa_temporizada
  import rampa_pkg::*;
#(
  parameter int DWELL_RAPIDO = DWELL_RAPIDO_DEF,
  parameter int DWELL_LENTO  = DWELL_LENTO_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  controlador_rampa_temporizada_if.slave bus
);

  localparam logic [CNT_W-1:0] CARGA_RAPIDO = CNT_W'(DWELL_RAPIDO - 1);
  localparam logic [CNT_W-1:0] CARGA_LENTO  = CNT_W'(DWELL_LENTO - 1);

  estado_rampa_t    estado, estado_next;
  logic             subiendo, subiendo_next;
  logic             modo_rapido, modo_next;
  logic             cargar;
  logic             fin;
  logic             cmd;
  logic [CNT_W-1:0] valor;

  assign cmd   = (bus.Rapido | bus.Lento) & ~bus.Parar;
  // The mode being latched this cycle must already select the dwell loaded on start.
  assign valor = modo_next ? CARGA_RAPIDO : CARGA_LENTO;

  temporizador_paso #(.CNT_W(CNT_W)) u_temporizador (
    .clk    (clk),
    .reset  (reset),
    .cargar (cargar),
    .valor  (valor),
    .fin    (fin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= REPOSO;
      subiendo    <= 1'b0;
      modo_rapido <= 1'b0;
    end else begin
      estado      <= estado_next;
      subiendo    <= subiendo_next;
      modo_rapido <= modo_next;
    end
  end

  // A command change that disagrees with the direction wins over a completing step,
  // so a dropped command never pushes the motor one level higher.
  always_comb begin
    estado_next   = estado;
    subiendo_next = subiendo;
    modo_next     = modo_rapido;
    cargar        = 1'b0;
    if (bus.Falla) begin
      estado_next   = FALLA;
      subiendo_next = 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (cmd) begin
            estado_next   = VEL30;
            subiendo_next = 1'b1;
            modo_next     = bus.Rapido;
            cargar        = 1'b1;
          end
        end
        VEL30, VEL50, VEL100: begin
          if (subiendo != cmd) begin
            subiendo_next = cmd;
            cargar        = 1'b1;
          end else if (fin && !(subiendo && estado == VEL100)) begin
            estado_next = subiendo ? nivel_arriba(estado) : nivel_abajo(estado);
            cargar      = (estado_next != REPOSO);
          end
        end
        FALLA: begin
          if (bus.Reconocer) begin
            estado_next = REPOSO;
          end
        end
        default: begin
          estado_next   = REPOSO;
          subiendo_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_30       <= 1'b0;
      bus.out_50       <= 1'b0;
      bus.out_100      <= 1'b0;
      bus.en_marcha    <= 1'b0;
      bus.falla_activa <= 1'b0;
    end else begin
      bus.out_30       <= (estado_next == VEL30);
      bus.out_50       <= (estado_next == VEL50);
      bus.out_100      <= (estado_next == VEL100);
      bus.en_marcha    <= (estado_next == VEL30) || (estado_next == VEL50) ||
                          (estado_next == VEL100);
      bus.falla_activa <= (estado_next == FALLA);
    end
  end

  assign bus.estado_dbg = estado;

endmodule

// File: tb/tb_controlador_rampa_temporizada.sv
// Scoreboard bench for the ramp sequencer: directed test-plan sequences plus
// randomized level commands, checked against a level/elapsed-cycles reference model.
module tb_controlador_rampa_temporizada;
  import rampa_pkg::*;

  localparam int DR = 4;
  localparam int DL = 16;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controlador_rampa_temporizada_if bus();

  controlador_rampa_temporizada #(
    .DWELL_RAPIDO (DR),
    .DWELL_LENTO  (DL),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ciclo = 0;

  // Reference model: speed level 0..3, fault flag, direction, mode, cycles spent on the step.
  int m_nivel = 0;
  bit m_falla = 1'b0;
  bit m_up    = 1'b0;
  bit m_fast  = 1'b0;
  int m_held  = 0;

  task automatic modelo_paso(input bit rst, r, l, p, f, k);
    bit cmd;
    int dwell;
    cmd = (r | l) & ~p;
    if (rst) begin
      m_nivel = 0; m_falla = 1'b0; m_up = 1'b0; m_fast = 1'b0; m_held = 0;
    end else if (f) begin
      m_falla = 1'b1; m_nivel = 0; m_up = 1'b0;
    end else if (m_falla) begin
      if (k) m_falla = 1'b0;
    end else if (m_nivel == 0) begin
      if (cmd) begin
        m_nivel = 1; m_up = 1'b1; m_fast = r; m_held = 1;
      end
    end else begin
      dwell = m_fast ? DR : DL;
      if (m_up != cmd) begin
        m_up = cmd; m_held = 1;
      end else if (m_held >= dwell && !(m_up && m_nivel == 3)) begin
        m_nivel = m_up ? m_nivel + 1 : m_nivel - 1;
        m_held = 1;
        if (m_nivel == 0) m_up = 1'b0;
      end else if (m_held < 1000) begin
        m_held = m_held + 1;
      end
    end
  endtask

  function automatic logic [W-1:0] modelo_salida();
    estado_rampa_t e;
    if (m_falla) e = FALLA;
    else if (m_nivel == 1) e = VEL30;
    else if (m_nivel == 2) e = VEL50;
    else if (m_nivel == 3) e = VEL100;
    else e = REPOSO;
    return {m_nivel == 1, m_nivel == 2, m_nivel == 3, (m_nivel != 0) && !m_falla, m_falla, e};
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then wait for the falling edge.
  task automatic drive_cycle(input bit rst, r, l, p, f, k);
    reset         = rst;
    bus.Rapido    = r;
    bus.Lento     = l;
    bus.Parar     = p;
    bus.Falla     = f;
    bus.Reconocer = k;
    modelo_paso(rst, r, l, p, f, k);
    exp_q.push_back(modelo_salida());
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] esperado;
    logic [W-1:0] obtenido;
    if (exp_q.size() != 0) begin
      esperado = exp_q.pop_front();
      obtenido = {bus.out_30, bus.out_50, bus.out_100, bus.en_marcha, bus.falla_activa,
                  bus.estado_dbg};
      n_cmp = n_cmp + 1;
      if (obtenido !== esperado) begin
        n_err = n_err + 1;
        $display("FAIL salidas ciclo %0d: obtenido %b esperado %b (o30 o50 o100 marcha falla estado)",
                 ciclo, obtenido, esperado);
      end
      ciclo = ciclo + 1;
    end
  end

  initial begin
    bit r, l, p, f, k, rst;
    int espera;
    // Reset state.
    repeat (3) drive_cycle(1, 0, 0, 0, 0, 0);
    // Fast ramp up, drop to ramp down, reassert during out_50, then full stop.
    repeat (14) drive_cycle(0, 1, 0, 0, 0, 0);
    repeat (6)  drive_cycle(0, 0, 0, 0, 0, 0);
    repeat (8)  drive_cycle(0, 1, 0, 0, 0, 0);
    repeat (16) drive_cycle(0, 0, 0, 0, 0, 0);
    // Slow ramp; Rapido joins at cycle 10 without changing the dwell.
    repeat (10) drive_cycle(0, 0, 1, 0, 0, 0);
    repeat (30) drive_cycle(0, 1, 1, 0, 0, 0);
    repeat (52) drive_cycle(0, 0, 0, 0, 0, 0);
    // Fault in VEL50, acknowledge blocked while Falla high, then cleared.
    repeat (6)  drive_cycle(0, 1, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 1, 0);
    repeat (3)  drive_cycle(0, 1, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    repeat (2)  drive_cycle(0, 0, 0, 0, 0, 0);
    // Parar beats Rapido in REPOSO; both commands high give fast steps.
    repeat (4)  drive_cycle(0, 1, 0, 1, 0, 0);
    repeat (12) drive_cycle(0, 1, 1, 0, 0, 0);
    repeat (20) drive_cycle(0, 0, 0, 0, 0, 0);
    // Reset mid-ramp with Rapido held, then restart.
    repeat (6)  drive_cycle(0, 1, 0, 0, 0, 0);
    repeat (2)  drive_cycle(1, 1, 0, 0, 0, 0);
    repeat (5)  drive_cycle(0, 1, 0, 0, 0, 0);
    // Randomized level commands with occasional faults and resets.
    r = 0; l = 0; p = 0; f = 0;
    repeat (3000) begin
      if ($urandom_range(0, 11) == 0) r = ~r;
      if ($urandom_range(0, 13) == 0) l = ~l;
      if ($urandom_range(0, 19) == 0) p = ~p;
      if (f) f = ($urandom_range(0, 2) != 0);
      else   f = ($urandom_range(0, 59) == 0);
      k   = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      drive_cycle(rst, r, l, p, f, k);
    end
    espera = 0;
    while (exp_q.size() != 0 && espera < 10) begin
      @(negedge clk);
      espera = espera + 1;
    end
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drenaje: quedan %0d esperados, requerido 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_rampa_temporizada.md
# controlador_rampa_temporizada

Timed soft-start sequencer for the motor speed stage. Turns the operator's level commands (`Rapido`, `Lento`) and the `Parar`/`Falla` inputs into a timed ramp of one-hot speed levels: 0 → 30 % → 50 % → 100 % going up, and 100 % → 50 % → 30 % → 0 going down. Each step dwells for a programmable number of clock cycles, set by the ramp mode latched at start. The block drives the power-stage level selects directly and reports run and fault status to the panel logic.

## Interface
- `DWELL_RAPIDO`, default 4: cycles spent on each step in fast mode; must be ≥1.
- `DWELL_LENTO`, default 16: cycles spent on each step in slow mode; must be ≥1.
- `CNT_W`, default 8: dwell counter width; must hold max(DWELL_RAPIDO, DWELL_LENTO)−1.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `Rapido` in 1: fast-ramp run command (level).
- `Lento` in 1: slow-ramp run command (level).
- `Parar` in 1: stop request (level); forces ramp-down.
- `Falla` in 1: fault input (level); forces immediate shutdown.
- `Reconocer` in 1: fault acknowledge (sampled per cycle).
- `out_30` out 1: 30 % level select.
- `out_50` out 1: 50 % level select.
- `out_100` out 1: 100 % level select.
- `en_marcha` out 1: high in any non-idle, non-fault state.
- `falla_activa` out 1: high in FALLA.

## Operation
- States: REPOSO, VEL30, VEL50, VEL100, FALLA. A direction flag `subiendo` (1 = ramping up) and a latched mode bit `modo_rapido` qualify the VEL states.
- Run command `cmd` = (`Rapido` | `Lento`) & ~`Parar`.
- Mode at start: `modo_rapido` = `Rapido`. `Rapido` wins if both commands are high. The mode is latched only on leaving REPOSO; later changes to `Rapido`/`Lento` mid-ramp do not alter the dwell.
- Dwell: `DWELL` = `modo_rapido` ? `DWELL_RAPIDO` : `DWELL_LENTO`. The counter is loaded with `DWELL`−1 on entry to any VEL state and on a direction flip, then decrements. A step completes when the counter is 0.
- REPOSO:
  - `cmd` → VEL30, `subiendo`=1.
  - Otherwise stay.
- VEL30 / VEL50, `subiendo`=1:
  - Step complete → next level up.
  - `cmd` drops → `subiendo`=0, counter reloaded, level held.
- VEL100: hold while `cmd`. When `cmd` drops → `subiendo`=0 and load the counter.
- Any VEL state, `subiendo`=0:
  - Step complete → next level down. VEL30 goes to REPOSO.
  - `cmd` reasserts → `subiendo`=1, counter reloaded, level held.
- Falla priority: `Falla`=1 in any state → FALLA on the next edge, overriding every other input.
- FALLA: leave to REPOSO only when `Falla`=0 and `Reconocer`=1 in the same cycle. If `Reconocer` and `Falla` are both high, stay in FALLA.
- Outputs are registered and decoded from the state. Exactly one of `out_30`/`out_50`/`out_100` is high in VEL states; all are 0 in REPOSO and FALLA.

## Timing
- Reset values: all outputs 0, state REPOSO, counter 0, `subiendo`=0, `modo_rapido`=0. Reset takes effect at the next rising edge, including mid-ramp, with no ramp-down.
- Start latency: if `cmd` is sampled at edge N, `out_30` is high from N+1.
- Each level is held for exactly `DWELL` cycles before the next level appears.
- Full up-ramp: `out_100` is high from N+1+2·`DWELL`.
- Ramp-down from VEL100: if `cmd` drops at edge M, `out_100` stays high through M+`DWELL`.
- Fault latency: 1 cycle.
- Fault clear latency: 1 cycle after the qualifying `Reconocer`.
- Simultaneous `Parar` and `Rapido` in REPOSO: `cmd`=0, so the block stays idle.

## Structure
- Package `rampa_pkg`: state enum `estado_rampa_t` (REPOSO, VEL30, VEL50, VEL100, FALLA) and the default dwell constants.
- Sub-module `temporizador_paso`: loadable down-counter with inputs `clk`, `reset`, `cargar`, `valor[CNT_W]` and output `fin`.
- Top level: FSM, direction and mode registers, output decode.

## Test plan
- Fast ramp: reset, then hold `Rapido`=1 from edge 0 → `out_30` on cycles 1–4, `out_50` on 5–8, `out_100` from 9; `en_marcha`=1 from 1.
- Slow ramp: `Lento` only → `out_30` on cycles 1–16, `out_50` on 17–32, `out_100` from 33. Assert `Rapido` at cycle 10 → timing unchanged.
- Ramp-down: fast mode at VEL100, drop `Rapido` → `out_100` for 4 more cycles, then `out_50` ×4, `out_30` ×4, then all zero and `en_marcha`=0. Reassert `Rapido` during `out_50` → `out_50` held 4 cycles, then `out_100`.
- Fault: `Falla`=1 during VEL50 → next cycle all levels 0, `falla_activa`=1. `Reconocer`=1 while `Falla`=1 → stays in FALLA. `Falla`=0 with `Reconocer`=1 → REPOSO next cycle.
- Priority: `Parar`=1 with `Rapido`=1 in REPOSO → stays idle. `Rapido` and `Lento` both high → 4-cycle steps.
- Reset mid-ramp: `reset` during `out_50` → all outputs 0 at the next edge. Releasing `reset` with `Rapido` high → `out_30` one cycle later.
